temp_bcd_encoder: RTL and testbench
===================================

Name: temp_bcd_encoder

Overview:
Producer side of the display's temperature interface. Accepts a binary temperature sample (°F) over a valid/ready handshake and converts it to the packed-BCD word the display controller consumes: {hundreds[1:0], tens[3:0], ones[3:0]}. Conversion is a sequential, one-bit-per-cycle double-dabble. The block also classifies the sample against a setpoint into a 2-bit status code for the status indicator blocks. Sits between the sensor/ADC front end and display_controller.

Parameters:
BAND, 2, half-width of the in-band window around the setpoint, in °F (0..63)
MAX_TEMP, 399, largest representable temperature; samples above it are clamped (must be <= 399)

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
IN_VALID  input  1  sample on IN_TEMP is valid
IN_READY  output  1  block can accept a sample this cycle
IN_TEMP  input  10  unsigned binary temperature, °F
SET_TEMP  input  10  unsigned binary setpoint, °F, sampled with IN_TEMP
TEMP_F  output  10  packed BCD result {hund[1:0], tens[3:0], ones[3:0]}, registered
STATUS  output  2  00 in band, 01 low, 10 high, 11 no data / over-range, registered
OUT_VALID  output  1  one-cycle pulse: TEMP_F/STATUS updated this cycle

Behaviour:
- Reset (async, RESET_N=0): state IDLE, TEMP_F=10'h000, STATUS=2'b11, OUT_VALID=0, IN_READY=1, internal regs cleared. Release takes effect on the next rising edge.
- States: IDLE -> CONV -> DONE -> IDLE.
- IDLE: IN_READY=1. Transfer occurs on a rising edge with IN_VALID=1 and IN_READY=1 (the accept edge, E0). At E0:
  - latch v = min(IN_TEMP, MAX_TEMP)
  - latch over = (IN_TEMP > MAX_TEMP)
  - clear the 12-bit BCD shift reg and the 4-bit iteration counter
  - compute the status and latch it into a pending register
  - go to CONV
- Status rule, computed with 11-bit unsigned arithmetic:
  - over -> 11
  - else v + BAND < SET_TEMP -> 01
  - else v > SET_TEMP + BAND -> 10
  - else 00
  - No underflow: SET_TEMP < BAND must not wrap. A sum above 1023 must not wrap.
- CONV: IN_READY=0. Edges E1..E10 each perform one iteration:
  - add 3 to every BCD digit >= 5
  - then shift {bcd, bin} left by one, MSB of bin into bcd[0]
  - increment the counter
  - After E10 (counter=10) go to DONE.
- DONE, edge E11:
  - TEMP_F <= bcd[9:0] (bcd[11:10] are always 0 because v <= 399)
  - STATUS <= pending status
  - OUT_VALID <= 1, go to IDLE
- OUT_VALID is high exactly for the cycle between E11 and E12, and returns to 0 at E12.
- IN_READY rises after E11, so the earliest next accept edge is E12. Throughput is one sample per 12 cycles.
- TEMP_F and STATUS change only at E11 and at reset. They hold their value between updates, so the display never sees a partial conversion.
- IN_TEMP and SET_TEMP are don't-care outside the accept edge. Changes during CONV have no effect.
- IN_VALID held high continuously: a new sample is accepted every 12 cycles. Samples offered while IN_READY=0 are not consumed; the source must hold them.
- Reset mid-conversion: the conversion is aborted, no OUT_VALID, outputs go to their reset values.
- Setpoint edge values: BAND=0 means in band only when v == SET_TEMP. A SET_TEMP above MAX_TEMP is legal; compare against the unclamped setpoint.

Test Plan:
- Reset, then IN_TEMP=72, SET_TEMP=70 (BAND=2), one-cycle IN_VALID -> OUT_VALID pulses 11 edges after accept; TEMP_F=10'b00_0111_0010, STATUS=00; IN_READY low for E0..E11 only.
- IN_TEMP=0, SET_TEMP=70 -> TEMP_F=10'h000, STATUS=01. Then IN_TEMP=399, SET_TEMP=70 -> TEMP_F=10'b11_1001_1001, STATUS=10.
- IN_TEMP=500 -> TEMP_F=10'b11_1001_1001 (clamped), STATUS=11. IN_TEMP=399 exactly -> STATUS not 11.
- SET_TEMP=1, BAND=2, IN_TEMP=0 -> STATUS=00 (no wrap). SET_TEMP=1023, IN_TEMP=399 -> STATUS=01.
- IN_VALID held high with IN_TEMP stepping 10,11,12… every cycle -> accepts occur exactly every 12 edges; the results match the value present on each accept edge; exactly one OUT_VALID per accept.
- Assert RESET_N low at E5 of a conversion -> no OUT_VALID; TEMP_F=000, STATUS=11, IN_READY=1. A fresh sample after release converts correctly.
- Exhaustive sweep IN_TEMP 0..399 -> TEMP_F matches the reference BCD for every value.

Source files
------------

// File: rtl/temp_bcd_encoder_if.sv
// -----------------------------------------------------------------------------
// temp_bcd_encoder_if
// Sample-in / result-out bundle between the sensor front end, the BCD encoder
// and the display controller.
//   IN_VALID  : sample on IN_TEMP/SET_TEMP is valid        (master -> slave)
//   IN_READY  : encoder can accept a sample this cycle       (slave -> master)
//   IN_TEMP   : unsigned binary temperature, degF            (master -> slave)
//   SET_TEMP  : unsigned binary setpoint, degF               (master -> slave)
//   TEMP_F    : packed BCD {hund[1:0], tens[3:0], ones[3:0]} (slave -> master)
//   STATUS    : 00 in band, 01 low, 10 high, 11 no data/over (slave -> master)
//   OUT_VALID : one-cycle pulse, TEMP_F/STATUS just updated  (slave -> master)
// -----------------------------------------------------------------------------
interface temp_bcd_encoder_if;
   logic       IN_VALID;
   logic       IN_READY;
   logic [9:0] IN_TEMP;
   logic [9:0] SET_TEMP;
   logic [9:0] TEMP_F;
   logic [1:0] STATUS;
   logic       OUT_VALID;

   // encoder side
   modport slave (
      input  IN_VALID, IN_TEMP, SET_TEMP,
      output IN_READY, TEMP_F, STATUS, OUT_VALID
   );

   // sample source / result consumer side
   modport master (
      output IN_VALID, IN_TEMP, SET_TEMP,
      input  IN_READY, TEMP_F, STATUS, OUT_VALID
   );
endinterface

// File: rtl/temp_bcd_encoder.sv
// -----------------------------------------------------------------------------
// temp_bcd_encoder
// Accepts a binary temperature sample over valid/ready, converts it to packed
// BCD with a one-bit-per-cycle double-dabble, and classifies it against the
// setpoint. One sample per 12 cycles: accept edge, 10 shift edges, 1 publish.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : temp_bcd_encoder_if.slave (handshake, sample, BCD result, status)
// Parameters:
//   BAND     : half-width of the in-band window around the setpoint (0..63)
//   MAX_TEMP : largest representable temperature, larger samples clamp (<=399)
// -----------------------------------------------------------------------------
module temp_bcd_encoder #(
   parameter int BAND     = 2,
   parameter int MAX_TEMP = 399
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   temp_bcd_encoder_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   localparam logic [9:0]  MAX_T  = 10'(MAX_TEMP);
   localparam logic [10:0] BAND_W = 11'(BAND);

   state_t      state, state_nxt;
   logic [9:0]  bin;          // binary operand, shifted out MSB first
   logic [9:0]  bcd;          // BCD accumulator, hundreds digit needs only 2 bits
   logic [9:0]  bcd_adj;
   logic [3:0]  cnt;
   logic [1:0]  pend_status;
   logic [9:0]  temp_f_q;
   logic [1:0]  status_q;
   logic        out_valid_q;
   logic        in_ready;
   logic        accept;
   logic        over;
   logic [9:0]  v_clamp;
   logic [10:0] lo_sum, hi_sum;
   logic [1:0]  status_calc;

   assign bus.IN_READY  = in_ready;
   assign bus.TEMP_F    = temp_f_q;
   assign bus.STATUS    = status_q;
   assign bus.OUT_VALID = out_valid_q;

   assign accept = bus.IN_VALID && in_ready;

   // ---------------- sample clamp and status classification ----------------
   // 11-bit sums so neither v+BAND nor SET_TEMP+BAND can wrap, and the
   // comparison is written as v+BAND < SET so a small setpoint never underflows.
   always_comb begin
      over        = (bus.IN_TEMP > MAX_T);
      v_clamp     = over ? MAX_T : bus.IN_TEMP;
      lo_sum      = {1'b0, v_clamp} + BAND_W;
      hi_sum      = {1'b0, bus.SET_TEMP} + BAND_W;
      status_calc = 2'b00;
      if (over)                             status_calc = 2'b11;
      else if (lo_sum < {1'b0, bus.SET_TEMP}) status_calc = 2'b01;
      else if ({1'b0, v_clamp} > hi_sum)    status_calc = 2'b10;
   end

   // ---------------- double-dabble add-3 step ----------------
   // Hundreds digit tops out at 3 (v <= 399) so it never needs the add-3.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 2; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.IN_VALID) state_nxt = CONV;
         end
         CONV:    if (cnt == 4'd9) state_nxt = DONE;  // 10th shift this edge
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         bin         <= '0;
         bcd         <= '0;
         cnt         <= '0;
         pend_status <= 2'b11;
         temp_f_q    <= '0;
         status_q    <= 2'b11;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               bin         <= v_clamp;
               bcd         <= '0;
               cnt         <= '0;
               pend_status <= status_calc;
            end
            CONV: begin
               {bcd, bin} <= {bcd_adj[8:0], bin, 1'b0};
               cnt        <= cnt + 4'd1;
            end
            DONE: begin
               temp_f_q    <= bcd;
               status_q    <= pend_status;
               out_valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_bcd_encoder.sv
// -----------------------------------------------------------------------------
// tb_temp_bcd_encoder
// Self-checking bench: directed vector table, streaming, reset abort,
// exhaustive BCD sweep and random samples against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_temp_bcd_encoder;

   localparam int BAND     = 2;
   localparam int MAX_TEMP = 399;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   temp_bcd_encoder_if bus ();

   temp_bcd_encoder #(.BAND(BAND), .MAX_TEMP(MAX_TEMP)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      string      name;
      logic [9:0] t;
      logic [9:0] s;
      logic [9:0] bcd;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[13];

   // ---------------- reference model ----------------
   function automatic logic [9:0] bcd_ref(input int t);
      int v;
      logic [9:0] r;
      v = (t > MAX_TEMP) ? MAX_TEMP : t;
      r = {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      return r;
   endfunction

   function automatic logic [1:0] status_ref(input int t, input int s);
      int v;
      if (t > MAX_TEMP) return 2'b11;
      v = t;
      if (v + BAND < s) return 2'b01;
      if (v > s + BAND) return 2'b10;
      return 2'b00;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One transfer: offer sample for one accept edge, then wait for OUT_VALID.
   task automatic xfer(input logic [9:0] t, input logic [9:0] s,
                       output logic [9:0] f, output logic [1:0] st,
                       output int lat, output int rdy_bad);
      int n;
      f = '0; st = '0; lat = -1; rdy_bad = 0;
      n = 0;
      @(negedge clk);
      while (!bus.IN_READY && n < 50) begin @(negedge clk); n++; end
      if (!bus.IN_READY) begin check("ready_timeout", 0, 1); return; end
      bus.IN_VALID = 1'b1; bus.IN_TEMP = t; bus.SET_TEMP = s;
      @(posedge clk);                         // E0
      @(negedge clk);
      bus.IN_VALID = 1'b0;
      bus.IN_TEMP  = 10'($urandom);           // must not disturb conversion
      bus.SET_TEMP = 10'($urandom);
      if (bus.IN_READY) rdy_bad++;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.OUT_VALID) begin
            lat = k; f = bus.TEMP_F; st = bus.STATUS;
            if (!bus.IN_READY) rdy_bad++;
            break;
         end
         if (bus.IN_READY) rdy_bad++;
      end
      if (lat < 0) check("out_valid_timeout", 0, 1);
   endtask

   logic [9:0] f;
   logic [1:0] st;
   int         lat, rdy_bad;

   initial begin
      vecs[0]  = '{"t72_s70",    10'd72,   10'd70,   10'h072, 2'b00};
      vecs[1]  = '{"t0_s70",     10'd0,    10'd70,   10'h000, 2'b01};
      vecs[2]  = '{"t399_s70",   10'd399,  10'd70,   10'h399, 2'b10};
      vecs[3]  = '{"t500_clamp", 10'd500,  10'd70,   10'h399, 2'b11};
      vecs[4]  = '{"t0_s1",      10'd0,    10'd1,    10'h000, 2'b00};
      vecs[5]  = '{"t399_s1023", 10'd399,  10'd1023, 10'h399, 2'b01};
      vecs[6]  = '{"t68_s70",    10'd68,   10'd70,   10'h068, 2'b00};
      vecs[7]  = '{"t67_s70",    10'd67,   10'd70,   10'h067, 2'b01};
      vecs[8]  = '{"t73_s70",    10'd73,   10'd70,   10'h073, 2'b10};
      vecs[9]  = '{"t1023_over", 10'd1023, 10'd1023, 10'h399, 2'b11};
      vecs[10] = '{"t400_over",  10'd400,  10'd0,    10'h399, 2'b11};
      vecs[11] = '{"t5_s0",      10'd5,    10'd0,    10'h005, 2'b10};
      vecs[12] = '{"t399_s400",  10'd399,  10'd400,  10'h399, 2'b00};

      bus.IN_VALID = 1'b0; bus.IN_TEMP = '0; bus.SET_TEMP = '0;
      rst_n = 1'b0;
      #15;
      check("rst_temp_f",    bus.TEMP_F,    10'h000);
      check("rst_status",    bus.STATUS,    2'b11);
      check("rst_out_valid", bus.OUT_VALID, 1'b0);
      check("rst_in_ready",  bus.IN_READY,  1'b1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // ---------------- directed table ----------------
      foreach (vecs[i]) begin
         xfer(vecs[i].t, vecs[i].s, f, st, lat, rdy_bad);
         check({vecs[i].name, "_bcd"},     f,       vecs[i].bcd);
         check({vecs[i].name, "_status"},  st,      vecs[i].st);
         check({vecs[i].name, "_latency"}, lat,     11);
         check({vecs[i].name, "_ready"},   rdy_bad, 0);
      end

      // ---------------- IN_VALID held high, temp stepping ----------------
      begin
         int q_t[$], q_e[$];
         int last_acc, n_acc, n_out;
         last_acc = -1; n_acc = 0; n_out = 0;
         bus.SET_TEMP = 10'd70;
         for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.OUT_VALID) begin
               n_out++;
               if (q_t.size() == 0) check("stream_extra_out", 1, 0);
               else begin
                  int t, e;
                  t = q_t.pop_front(); e = q_e.pop_front();
                  check("stream_latency", c - e, 12);
                  check("stream_bcd",     bus.TEMP_F, bcd_ref(t));
                  check("stream_status",  bus.STATUS, status_ref(t, 70));
               end
            end
            bus.IN_VALID = (c < 60);
            bus.IN_TEMP  = 10'(10 + c);
            if (bus.IN_VALID && bus.IN_READY) begin
               q_t.push_back(10 + c); q_e.push_back(c);
               if (last_acc >= 0) check("stream_interval", c - last_acc, 12);
               last_acc = c; n_acc++;
            end
         end
         bus.IN_VALID = 1'b0;
         check("stream_accepts", n_acc, 5);
         check("stream_outs",    n_out, n_acc);
      end

      // ---------------- reset in the middle of a conversion ----------------
      begin
         int pulses;
         pulses = 0;
         @(negedge clk);
         bus.IN_VALID = 1'b1; bus.IN_TEMP = 10'd250; bus.SET_TEMP = 10'd70;
         @(posedge clk);                      // E0
         @(negedge clk) bus.IN_VALID = 1'b0;
         repeat (5) @(posedge clk);           // E5
         #1 rst_n = 1'b0;
         #1;
         check("abort_temp_f",   bus.TEMP_F,   10'h000);
         check("abort_status",   bus.STATUS,   2'b11);
         check("abort_in_ready", bus.IN_READY, 1'b1);
         for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (bus.OUT_VALID) pulses++;
         end
         check("abort_no_out_valid", pulses, 0);
         xfer(10'd123, 10'd200, f, st, lat, rdy_bad);
         check("post_abort_bcd",    f,   10'h123);
         check("post_abort_status", st,  2'b01);
         check("post_abort_lat",    lat, 11);
      end

      // ---------------- exhaustive BCD sweep ----------------
      for (int t = 0; t <= MAX_TEMP; t++) begin
         int s;
         s = $urandom_range(0, 1023);
         xfer(10'(t), 10'(s), f, st, lat, rdy_bad);
         check($sformatf("sweep_bcd_%0d", t), f, bcd_ref(t));
         if (st !== status_ref(t, s)) check($sformatf("sweep_status_%0d", t), st, status_ref(t, s));
      end

      // ---------------- random samples ----------------
      for (int i = 0; i < 40; i++) begin
         int t, s;
         t = (i % 2) ? $urandom_range(0, 1023) : $urandom_range(0, 420);
         s = $urandom_range(0, 1023);
         if (i % 4 == 0) s = t + $urandom_range(0, 8) - 4;
         if (s < 0) s = 0;
         if (s > 1023) s = 1023;
         xfer(10'(t), 10'(s), f, st, lat, rdy_bad);
         check($sformatf("rand_bcd_t%0d", t),         f,  bcd_ref(t));
         check($sformatf("rand_status_t%0d_s%0d", t, s), st, status_ref(t, s));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
